// File: rtl/video_st_pkg.sv
// Shared video streaming definitions: pixel format, frame geometry and
// frame-alignment FSM encoding used by the Avalon-ST video blocks.
package video_st_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned FRAME_PIXELS = 307200;

  // RGB565 field positions within a pixel word
  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

endpackage

// File: rtl/video_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on rdata whenever
// the FIFO is not empty, with full/empty/level derived from a registered count.
module video_sync_fifo #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty))
    else $error("video_sync_fifo: pop while empty");

endmodule

// File: rtl/video_frame_fifo_source.sv
// Frame-aligning buffer between the video sink register stage and an
// Avalon-ST source: drops pre-sop beats, checks frame length, re-emits beats.
module video_frame_fifo_source #(
  parameter int unsigned DATA_W       = video_st_pkg::DATA_W,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned FRAME_PIXELS = video_st_pkg::FRAME_PIXELS,
  parameter int unsigned CNT_W        = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ready_reg,
  input  logic              valid_reg,
  input  logic [DATA_W-1:0] data_reg,
  input  logic              sop_reg,
  input  logic              eop_reg,
  input  logic              src_ready,
  output logic              src_valid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_sop,
  output logic              src_eop,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       drop_cnt
);

  import video_st_pkg::*;

  localparam int unsigned     ENTRY_W   = DATA_W + 2;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  READY_MAX = (ADDR_W+1)'(DEPTH - 2);

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0]       drop_q, drop_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q;
  logic              beat_new;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [ADDR_W:0]   fifo_level;

  // Keep room for the beat that may already sit in the sink registers
  assign ready_reg = (fifo_level <= READY_MAX);
  assign beat_new  = valid_reg && ready_q;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Alignment FSM, length check and drop counting on newly captured beats only
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fifo_push = 1'b0;
    if (beat_new) begin
      case (state_q)
        WAIT_SOP: begin
          if (!sop_reg) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            fifo_push = 1'b1;
            cnt_d     = CNT_ONE;
            if (eop_reg) begin
              if (CNT_ONE == FRAME_LEN) done_d = 1'b1;
              else                      err_d  = 1'b1;
            end else begin
              state_d = IN_FRAME;
            end
          end
        end
        IN_FRAME: begin
          fifo_push = 1'b1;
          if (sop_reg) begin
            err_d = 1'b1;
            cnt_d = CNT_ONE;
          end else if (eop_reg) begin
            cnt_d   = cnt_inc;
            state_d = WAIT_SOP;
            if (cnt_inc == FRAME_LEN) done_d = 1'b1;
            else                      err_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_SOP;
      cnt_q   <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_reg;
    end
  end

  video_sync_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({sop_reg, eop_reg, data_reg}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign src_valid = !fifo_empty;
  assign fifo_pop  = src_valid && src_ready;
  assign {src_sop, src_eop, src_data} = fifo_rdata;

  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign drop_cnt   = drop_q;

  assert property (@(posedge clk) disable iff (!reset_n) !(fifo_push && fifo_full))
    else $error("video_frame_fifo_source: write while FIFO full");

endmodule

// File: tb/tb_video_frame_fifo_source.sv
// Bench for video_frame_fifo_source: models the upstream sink register stage,
// scoreboards emitted beats and checks frame pulses and drop counts per scenario.
module tb_video_frame_fifo_source;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned FRAME_PIXELS = 16;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    int    junk;
    int    len;
    int    sop_at;
    int    mode;       // 0 ready high, 1 stall, 2 toggle
    int    stall_at;
    int    stall_len;
    int    exp_drop;
    int    exp_done;
    int    exp_err;
    string name;
  } scen_t;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              ready_reg;
  logic              valid_reg = 1'b0;
  logic [DATA_W-1:0] data_reg  = '0;
  logic              sop_reg   = 1'b0;
  logic              eop_reg   = 1'b0;
  logic              src_ready = 1'b1;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_sop;
  logic              src_eop;
  logic              frame_done;
  logic              frame_err;
  logic [15:0]       drop_cnt;

  beat_t up_q[$];
  beat_t sb_q[$];
  bit    model_aligned = 1'b0;
  int    pending = 0;
  int    n_cmp = 0, n_fail = 0;
  int    done_seen = 0, err_seen = 0;
  int    exp_drop_tot = 0, exp_done_tot = 0, exp_err_tot = 0;
  int    seq = 0;

  video_frame_fifo_source #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FRAME_PIXELS),
    .CNT_W        (19)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ready_reg  (ready_reg),
    .valid_reg  (valid_reg),
    .data_reg   (data_reg),
    .sop_reg    (sop_reg),
    .eop_reg    (eop_reg),
    .src_ready  (src_ready),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] next_data();
    seq++;
    return DATA_W'(32'(seq) * 32'd40503 + 32'd4660);
  endfunction

  // Sink register stage: captures a new beat only on edges where ready_reg was high
  initial begin : sink_model
    logic  r;
    beat_t b;
    forever begin
      @(negedge clk);
      r = ready_reg;
      @(posedge clk);
      #1;
      pending = 0;
      if (!reset_n) begin
        valid_reg = 1'b0;
        sop_reg   = 1'b0;
        eop_reg   = 1'b0;
        data_reg  = '0;
        sb_q.delete();
        up_q.delete();
        model_aligned = 1'b0;
      end else if (r) begin
        if (up_q.size() > 0) begin
          b = up_q.pop_front();
          valid_reg = 1'b1;
          sop_reg   = b.sop;
          eop_reg   = b.eop;
          data_reg  = b.data;
          if (model_aligned || b.sop) begin
            sb_q.push_back(b);
            pending = 1;
          end
          if (b.sop)      model_aligned = !b.eop;
          else if (b.eop) model_aligned = 1'b0;
        end else begin
          valid_reg = 1'b0;
        end
      end
    end
  end

  // Output side: occupancy/ready relation, pulse counting, beat scoreboard
  initial begin : out_monitor
    beat_t e;
    int    occ;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        occ = sb_q.size() - pending;
        check("ready_vs_occupancy", 32'(ready_reg), 32'(occ <= int'(DEPTH) - 2));
        if (frame_done) done_seen++;
        if (frame_err)  err_seen++;
        if (src_valid && src_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t",
                     {src_sop, src_eop, src_data}, $time);
          end else begin
            e = sb_q.pop_front();
            check("out_beat", 32'({src_sop, src_eop, src_data}), 32'(e));
          end
        end
      end
    end
  end

  task automatic run_scen(input scen_t s);
    beat_t b;
    int    budget;
    for (int i = 0; i < s.junk; i++) begin
      b.sop = 1'b0; b.eop = 1'b0; b.data = next_data();
      up_q.push_back(b);
    end
    for (int i = 0; i < s.len; i++) begin
      b.sop  = (i == 0) || (s.sop_at != 0 && i == s.sop_at);
      b.eop  = (i == s.len - 1);
      b.data = next_data();
      up_q.push_back(b);
    end
    if (s.mode != 0) begin
      repeat (s.stall_at) @(posedge clk);
      #2;
      for (int k = 0; k < s.stall_len; k++) begin
        src_ready = (s.mode == 2) ? 1'(k % 2) : 1'b0;
        @(posedge clk);
        #2;
      end
      src_ready = 1'b1;
    end
    budget = 0;
    while ((up_q.size() != 0 || sb_q.size() != 0 || pending != 0) && budget < 1000) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check({s.name, "_drain"}, 32'(budget < 1000), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    exp_drop_tot += s.exp_drop;
    exp_done_tot += s.exp_done;
    exp_err_tot  += s.exp_err;
    check({s.name, "_drop_cnt"},   32'(drop_cnt),  32'(exp_drop_tot));
    check({s.name, "_frame_done"}, 32'(done_seen), 32'(exp_done_tot));
    check({s.name, "_frame_err"},  32'(err_seen),  32'(exp_err_tot));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    scen_t tab[9];
    scen_t post_reset;
    beat_t b;
    int    budget;

    tab[0] = '{0, 16, 0, 0, 0,  0, 0, 1, 0, "frame16"};
    tab[1] = '{3, 16, 0, 0, 0,  0, 3, 1, 0, "junk3_frame16"};
    tab[2] = '{0, 16, 0, 1, 4, 20, 0, 1, 0, "stall20"};
    tab[3] = '{0, 16, 0, 2, 2, 30, 0, 1, 0, "ready_toggle"};
    tab[4] = '{0, 12, 0, 0, 0,  0, 0, 0, 1, "short_eop12"};
    tab[5] = '{0, 16, 7, 0, 0,  0, 0, 0, 2, "sop_at8_len16"};
    tab[6] = '{0, 23, 7, 0, 0,  0, 0, 1, 1, "sop_at8_restart"};
    tab[7] = '{0,  1, 0, 0, 0,  0, 0, 0, 1, "sop_eop_single"};
    tab[8] = '{2, 17, 0, 1, 6, 12, 2, 0, 1, "junk2_long17"};
    post_reset = '{0, 16, 0, 0, 0, 0, 0, 1, 0, "after_reset"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_valid",  32'(src_valid),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
    check("rst_src_data",   32'(src_data),   32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 9; i++) run_scen(tab[i]);

    // Reset in the middle of a frame with five beats buffered
    src_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b.sop = (i == 0); b.eop = 1'b0; b.data = next_data();
      up_q.push_back(b);
    end
    budget = 0;
    while ((up_q.size() != 0 || pending != 0) && budget < 100) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check("midframe_fill", 32'(budget < 100), 32'd1);
    @(negedge clk);
    check("midframe_src_valid", 32'(src_valid), 32'd1);
    check("midframe_sb_level",  32'(sb_q.size()), 32'd5);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_src_valid", 32'(src_valid), 32'd0);
    check("midrst_drop_cnt",  32'(drop_cnt),  32'd0);
    exp_drop_tot = 0;
    @(posedge clk);
    #2;
    reset_n   = 1'b1;
    src_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    run_scen(post_reset);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
